// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and LED codes for the pedestrian crossing controller.
//   state_e  : controller state (GREEN, YELLOW, WALK, CLEAR)
//   CAR_*    : active-low, one-cold car light codes
//   PED_*    : active-low pedestrian light codes (bit0 walk, bit1 don't-walk)
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        WALK   = 2'd2,
        CLEAR  = 2'd3
    } state_e;

    localparam logic [2:0] CAR_GREEN  = 3'b110;
    localparam logic [2:0] CAR_YELLOW = 3'b101;
    localparam logic [2:0] CAR_RED    = 3'b011;

    localparam logic [1:0] PED_WALK   = 2'b10;
    localparam logic [1:0] PED_DONT   = 2'b01;
    // Clearance phase, flash "on" half: walk and don't-walk both lit.
    localparam logic [1:0] PED_BOTH   = 2'b00;

    function automatic logic [2:0] car_code(input state_e s);
        logic [2:0] code;
        code = CAR_RED;
        case (s)
            GREEN:   code = CAR_GREEN;
            YELLOW:  code = CAR_YELLOW;
            default: code = CAR_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw active-low push-button, debounces it and emits a single
// one-cycle press pulse on each debounced 1->0 transition.
//   sys_clk   in   system clock
//   sys_rst_n in   asynchronous active-low reset
//   btn_n     in   raw button, active-low, asynchronous, bouncy
//   level     out  debounced button level (idle 1)
//   press     out  one-cycle pulse, registered, one cycle after level falls
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEB_TICKS = 320_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic [1:0]    sync_q,       sync_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          level_q,      level_d;
    logic          level_prev_q, level_prev_d;
    logic          press_q,      press_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        sync_d       = {sync_q[0], btn_n};
        cnt_d        = cnt_q;
        level_d      = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Mismatch has persisted for DEB_TICKS cycles: accept it.
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        level_prev_d = level_q;
        press_d      = level_prev_q & ~level_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// -----------------------------------------------------------------------------
// ped_crossing_ctrl
// Pedestrian-request traffic controller. Latches debounced button presses and
// sequences car light GREEN -> YELLOW -> (ped WALK) -> (ped CLEAR) -> GREEN,
// timed by a 1 s prescaler tick and a per-state seconds counter.
//   sys_clk   in   system clock
//   sys_rst_n in   asynchronous active-low reset
//   ped_btn_n in   raw pedestrian button, active-low, asynchronous, bouncy
//   car_led   out  [2:0] car light, active-low one-cold (110 G, 101 Y, 011 R)
//   ped_led   out  [1:0] pedestrian light, active-low (bit0 walk, bit1 don't)
//   req_led   out  active-low, 0 while a request is latched
// All outputs are registered and decoded from the next state so they change
// on the same edge as the state register.
// -----------------------------------------------------------------------------
module ped_crossing_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned SEC_TICKS   = 32_000_000,
    parameter int unsigned DEB_TICKS   = 320_000,
    parameter int unsigned GREEN_MIN_S = 5,
    parameter int unsigned YELLOW_S    = 2,
    parameter int unsigned WALK_S      = 6,
    parameter int unsigned CLEAR_S     = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ped_btn_n,
    output logic [2:0] car_led,
    output logic [1:0] ped_led,
    output logic       req_led
);

    localparam int PW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SEC_TICKS - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(SEC_TICKS / 2);

    logic       deb_level;
    logic       press_evt;

    state_e     state_q,   state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0] sec_q,     sec_d;
    logic       req_q,     req_d;
    logic [2:0] car_led_q, car_led_d;
    logic [1:0] ped_led_q, ped_led_d;
    logic       req_led_q, req_led_d;

    logic       tick;
    logic       state_chg;

    btn_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_btn_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_n     (ped_btn_n),
        .level     (deb_level),
        .press     (press_evt)
    );

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            GREEN:  if (sec_q >= 8'(GREEN_MIN_S) && req_q)        state_d = YELLOW;
            YELLOW: if (tick && sec_q == 8'(YELLOW_S - 1))        state_d = WALK;
            WALK:   if (tick && sec_q == 8'(WALK_S - 1))          state_d = CLEAR;
            CLEAR:  if (tick && sec_q == 8'(CLEAR_S - 1))         state_d = GREEN;
            default:                                              state_d = GREEN;
        endcase

        state_chg = (state_d != state_q);

        // Prescaler and seconds restart on every state change so each timed
        // state lasts an exact multiple of SEC_TICKS cycles.
        presc_d = (state_chg || tick) ? '0 : presc_q + PW'(1);
        if (state_chg) begin
            sec_d = '0;
        end else if (tick && sec_q != 8'hFF) begin
            sec_d = sec_q + 8'd1;
        end else begin
            sec_d = sec_q;
        end

        // Clear on WALK entry has priority over a coincident press.
        if (state_d == WALK && state_q != WALK) begin
            req_d = 1'b0;
        end else if (press_evt && state_q != WALK) begin
            req_d = 1'b1;
        end else begin
            req_d = req_q;
        end

        car_led_d = car_code(state_d);
        case (state_d)
            WALK:    ped_led_d = PED_WALK;
            // presc_d is what presc_q will hold alongside this LED value.
            CLEAR:   ped_led_d = (presc_d < PRESC_HALF) ? PED_BOTH : PED_DONT;
            default: ped_led_d = PED_DONT;
        endcase
        req_led_d = ~req_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= GREEN;
            presc_q   <= '0;
            sec_q     <= '0;
            req_q     <= 1'b0;
            car_led_q <= CAR_GREEN;
            ped_led_q <= PED_DONT;
            req_led_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            req_q     <= req_d;
            car_led_q <= car_led_d;
            ped_led_q <= ped_led_d;
            req_led_q <= req_led_d;
        end
    end

    assign car_led = car_led_q;
    assign ped_led = ped_led_q;
    assign req_led = req_led_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ped_crossing_ctrl
// Scoreboard bench for ped_crossing_ctrl with small timing parameters.
// Edge numbering: edge n is the n-th rising edge after reset release, so the
// prescaler holds n mod SEC_TICKS after edge n. Each expected output change is
// queued as {edge, car, ped, req}; the monitor pops one entry whenever the
// outputs change and compares both the values and the edge it happened on.
// -----------------------------------------------------------------------------
module tb_ped_crossing_ctrl;

    localparam int SEC = 10;
    localparam int DEB = 4;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       ped_btn_n = 1'b1;
    logic [2:0] car_led;
    logic [1:0] ped_led;
    logic       req_led;

    int  edge_cnt;
    int  n_checks = 0;
    int  n_fails  = 0;
    bit  mon_en   = 1'b0;
    logic [5:0] prev_out;

    typedef struct {
        int         edge_n;
        logic [2:0] car;
        logic [1:0] ped;
        logic       req;
    } exp_t;

    exp_t exp_q[$];

    ped_crossing_ctrl #(
        .SEC_TICKS   (SEC),
        .DEB_TICKS   (DEB),
        .GREEN_MIN_S (3),
        .YELLOW_S    (2),
        .WALK_S      (4),
        .CLEAR_S     (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ped_btn_n (ped_btn_n),
        .car_led   (car_led),
        .ped_led   (ped_led),
        .req_led   (req_led)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) edge_cnt <= 0;
        else            edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge sys_clk) begin
        logic [5:0] cur;
        exp_t       e;
        cur = {car_led, ped_led, req_led};
        if (!sys_rst_n || !mon_en) begin
            prev_out = cur;
        end else if (cur !== prev_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_change: got %b at edge %0d, expected %b unchanged",
                         cur, edge_cnt, prev_out);
            end else begin
                e = exp_q.pop_front();
                check("event_edge", edge_cnt, e.edge_n);
                check("event_leds", {26'd0, cur}, {26'd0, e.car, e.ped, e.req});
            end
            prev_out = cur;
        end
    end

    task automatic push_exp(input int e, input logic [2:0] c, input logic [1:0] p, input logic r);
        exp_t x;
        x.edge_n = e;
        x.car    = c;
        x.ped    = p;
        x.req    = r;
        exp_q.push_back(x);
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_car"}, {29'd0, car_led}, 32'b110);
        check({tag, "_ped"}, {30'd0, ped_led}, 32'b01);
        check({tag, "_req"}, {31'd0, req_led}, 32'd1);
    endtask

    task automatic end_phase(input string tag);
        #1;
        check({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Full crossing after a press first sampled at edge 6: req_led low at
    // 6+DEB+3=13; sec_cnt reaches 3 at edge 30, so YELLOW at 31; YELLOW 20,
    // WALK 40, CLEAR 20 (walk bit toggling every 5) cycles; GREEN at 111.
    task automatic push_std();
        push_exp(13,  3'b110, 2'b01, 1'b0);
        push_exp(31,  3'b101, 2'b01, 1'b0);
        push_exp(51,  3'b011, 2'b10, 1'b1);
        push_exp(91,  3'b011, 2'b00, 1'b1);
        push_exp(96,  3'b011, 2'b01, 1'b1);
        push_exp(101, 3'b011, 2'b00, 1'b1);
        push_exp(106, 3'b011, 2'b01, 1'b1);
        push_exp(111, 3'b110, 2'b01, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase 1: idle, no button.
        ped_btn_n = 1'b1;
        do_reset();
        check_reset_vals("rst");
        wait_edge(200);
        check_reset_vals("idle");
        end_phase("idle");

        // Phase 2: five 3-cycle glitches, 2 cycles apart.
        ped_btn_n = 1'b1;
        do_reset();
        wait_edge(10);
        for (int i = 0; i < 5; i++) begin
            ped_btn_n = 1'b0;
            repeat (3) @(negedge sys_clk);
            ped_btn_n = 1'b1;
            repeat (2) @(negedge sys_clk);
        end
        wait_edge(100);
        check("bounce_req", {31'd0, req_led}, 32'd1);
        end_phase("bounce");

        // Phase 3: clean press held, full cycle, then GREEN holds.
        ped_btn_n = 1'b1;
        do_reset();
        push_std();
        wait_edge(5);
        ped_btn_n = 1'b0;
        wait_edge(150);
        ped_btn_n = 1'b1;
        wait_edge(250);
        check("hold_car", {29'd0, car_led}, 32'b110);
        end_phase("clean");

        // Phase 4: second press (first sampled at edge 60) during WALK.
        ped_btn_n = 1'b1;
        do_reset();
        push_std();
        wait_edge(5);
        ped_btn_n = 1'b0;
        wait_edge(20);
        ped_btn_n = 1'b1;
        wait_edge(59);
        ped_btn_n = 1'b0;
        wait_edge(80);
        check("walk_press_req", {31'd0, req_led}, 32'd1);
        wait_edge(250);
        check("walk_press_car", {29'd0, car_led}, 32'b110);
        end_phase("walk_press");

        // Phase 5: second press first sampled at edge 93 (CLEAR); request
        // latched at 100, GREEN at 111, sec_cnt=3 at 141, YELLOW at 142,
        // WALK at 162.
        ped_btn_n = 1'b1;
        do_reset();
        push_exp(13,  3'b110, 2'b01, 1'b0);
        push_exp(31,  3'b101, 2'b01, 1'b0);
        push_exp(51,  3'b011, 2'b10, 1'b1);
        push_exp(91,  3'b011, 2'b00, 1'b1);
        push_exp(96,  3'b011, 2'b01, 1'b1);
        push_exp(100, 3'b011, 2'b01, 1'b0);
        push_exp(101, 3'b011, 2'b00, 1'b0);
        push_exp(106, 3'b011, 2'b01, 1'b0);
        push_exp(111, 3'b110, 2'b01, 1'b0);
        push_exp(142, 3'b101, 2'b01, 1'b0);
        push_exp(162, 3'b011, 2'b10, 1'b1);
        wait_edge(5);
        ped_btn_n = 1'b0;
        wait_edge(20);
        ped_btn_n = 1'b1;
        wait_edge(92);
        ped_btn_n = 1'b0;
        wait_edge(170);
        end_phase("clear_press");

        // Phase 6: reset mid-WALK with the button still held. After release
        // the press is first sampled at edge 1: req_led low at 8, YELLOW at 31.
        ped_btn_n = 1'b1;
        do_reset();
        push_exp(13, 3'b110, 2'b01, 1'b0);
        push_exp(31, 3'b101, 2'b01, 1'b0);
        push_exp(51, 3'b011, 2'b10, 1'b1);
        wait_edge(5);
        ped_btn_n = 1'b0;
        wait_edge(70);
        #2;
        mon_en    = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        check("pre_reset_pending", exp_q.size(), 0);
        repeat (3) @(negedge sys_clk);
        push_exp(8,  3'b110, 2'b01, 1'b0);
        push_exp(31, 3'b101, 2'b01, 1'b0);
        push_exp(51, 3'b011, 2'b10, 1'b1);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;
        wait_edge(60);
        end_phase("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
